// File: rtl/keypad_encoder_if.sv
// Keypad encoder bundle: keypad matrix lines plus the byte/strobe handshake to the calculator.
// master = encoder side, slave = keypad/consumer side.
interface keypad_encoder_if;
   logic [3:0] row;
   logic [3:0] col;
   logic [7:0] data;
   logic       done;
   logic       start;
   logic       busy;

   modport master (input row, output col, data, done, start, busy);
   modport slave  (output row, input col, data, done, start, busy);
endinterface

// File: rtl/keypad_encoder.sv
// 4x4 active-low keypad scanner/encoder emitting one ASCII byte per debounced press.
// Optional macro KP_STAR_START_EN: '*' pulses start instead of done.
//
// state  | meaning
// S_SCAN | drive columns in turn, look for any low row at each sample
// S_DEB  | column held, count matching samples of the latched row
// S_EMIT | single cycle after data/strobe were loaded
// S_REL  | column held, count all-high samples before resuming scan
module keypad_encoder #(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 4
) (
   input logic              clk,
   input logic              rst,
   keypad_encoder_if.master kp
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int MW = $clog2(DEBOUNCE + 1);

   typedef enum logic [1:0] {S_SCAN, S_DEB, S_EMIT, S_REL} state_t;

   state_t        state;
   logic [3:0]    sync1, rs;
   logic [CW-1:0] dwell;
   logic [1:0]    c, r, hit_r;
   logic [MW-1:0] mcnt;
   logic [3:0]    col_q;
   logic [7:0]    data_q;
   logic          done_q, start_q, busy_q;
   logic          sample, go_emit;

   function automatic logic [1:0] low_row(input logic [3:0] v);
      if (!v[0])      return 2'd0;
      else if (!v[1]) return 2'd1;
      else if (!v[2]) return 2'd2;
      else            return 2'd3;
   endfunction

   function automatic logic [3:0] col_drive(input logic [1:0] cc);
      return ~(4'b0001 << cc);
   endfunction

   function automatic logic [7:0] ascii(input logic [1:0] rr, input logic [1:0] cc);
      case ({rr, cc})
         4'h0: return 8'h31;  4'h1: return 8'h32;  4'h2: return 8'h33;  4'h3: return 8'h41;
         4'h4: return 8'h34;  4'h5: return 8'h35;  4'h6: return 8'h36;  4'h7: return 8'h42;
         4'h8: return 8'h37;  4'h9: return 8'h38;  4'hA: return 8'h39;  4'hB: return 8'h43;
         4'hC: return 8'h2A;  4'hD: return 8'h30;  4'hE: return 8'h23;  default: return 8'h44;
      endcase
   endfunction

   assign sample = (dwell == CW'(SCAN_DIV - 1));

   // Strobe is loaded on the edge that enters S_EMIT so done lands one cycle after the final sample.
   always_comb begin
      hit_r   = (state == S_SCAN) ? low_row(rs) : r;
      go_emit = 1'b0;
      if (sample) begin
         if (state == S_SCAN && rs != 4'hF && DEBOUNCE == 1)
            go_emit = 1'b1;
         if (state == S_DEB && !rs[r] && (mcnt + MW'(1)) == MW'(DEBOUNCE))
            go_emit = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_SCAN;
         sync1   <= 4'hF;
         rs      <= 4'hF;
         dwell   <= '0;
         c       <= 2'd0;
         r       <= 2'd0;
         mcnt    <= '0;
         col_q   <= 4'b1110;
         data_q  <= 8'h00;
         done_q  <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync1   <= kp.row;
         rs      <= sync1;
         done_q  <= 1'b0;
         start_q <= 1'b0;
         // Column changes only happen on a sample, where the dwell wraps to 0 anyway.
         dwell   <= sample ? '0 : dwell + CW'(1);
         case (state)
            S_SCAN: if (sample) begin
               if (rs == 4'hF) begin
                  c     <= c + 2'd1;
                  col_q <= col_drive(c + 2'd1);
               end else begin
                  r      <= hit_r;
                  mcnt   <= MW'(1);
                  busy_q <= 1'b1;
                  state  <= go_emit ? S_EMIT : S_DEB;
               end
            end
            S_DEB: if (sample) begin
               if (!rs[r]) begin
                  mcnt <= mcnt + MW'(1);
                  if (go_emit) state <= S_EMIT;
               end else begin
                  state  <= S_SCAN;
                  busy_q <= 1'b0;
                  c      <= c + 2'd1;
                  col_q  <= col_drive(c + 2'd1);
               end
            end
            S_EMIT: begin
               state <= S_REL;
               mcnt  <= '0;
            end
            S_REL: if (sample) begin
               if (rs != 4'hF)
                  mcnt <= '0;
               else if ((mcnt + MW'(1)) == MW'(DEBOUNCE)) begin
                  state  <= S_SCAN;
                  busy_q <= 1'b0;
                  mcnt   <= '0;
                  c      <= c + 2'd1;
                  col_q  <= col_drive(c + 2'd1);
               end else
                  mcnt <= mcnt + MW'(1);
            end
            default: state <= S_SCAN;
         endcase
         if (go_emit) begin
            data_q <= ascii(hit_r, c);
`ifdef KP_STAR_START_EN
            if (hit_r == 2'd3 && c == 2'd0) start_q <= 1'b1;
            else                            done_q  <= 1'b1;
`else
            done_q <= 1'b1;
`endif
         end
      end
   end

   assign kp.col   = col_q;
   assign kp.data  = data_q;
   assign kp.done  = done_q;
   assign kp.start = start_q;
   assign kp.busy  = busy_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: emulated 4x4 keypad matrix, scenario tasks and randomized presses
// checked against a key-map/timing model.
module tb_keypad_encoder;
   localparam int SD  = 4;
   localparam int DB  = 2;
   localparam int LAT = (DB - 1) * SD + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   keypad_encoder_if kp();
   keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (.clk(clk), .rst(rst), .kp(kp));

   // kcol[c][r] = 1 means the key at row r, column c is held down
   logic [3:0] kcol [4];
   assign kp.row = ~((kcol[0] & {4{~kp.col[0]}}) | (kcol[1] & {4{~kp.col[1]}}) |
                     (kcol[2] & {4{~kp.col[2]}}) | (kcol[3] & {4{~kp.col[3]}}));

   string keymap [4] = '{"123A", "456B", "789C", "*0#D"};

   int   total = 0, bad = 0;
   int   cyc = 0, done_cnt = 0, start_cnt = 0, last_done_cyc = 0, last_strobe_cyc = 0, busy_rise_cyc = 0;
   logic prev_busy = 1'b0, prev_done = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (kp.done === 1'b1 || kp.start === 1'b1) begin
         total++;
         if ((kp.done && kp.start) || (kp.done && prev_done)) begin
            bad++;
            $display("FAIL strobe_shape done=%b start=%b prev_done=%b (need single-cycle, exclusive)",
                     kp.done, kp.start, prev_done);
         end
      end
      if (kp.done === 1'b1) begin done_cnt++; last_done_cyc = cyc; last_strobe_cyc = cyc; end
      if (kp.start === 1'b1) begin start_cnt++; last_strobe_cyc = cyc; end
      if (kp.busy === 1'b1 && !prev_busy) busy_rise_cyc = cyc;
      prev_busy = kp.busy;
      prev_done = kp.done;
   end

   function automatic logic [7:0] key_code(input int rr, input int cc);
      return keymap[rr].getc(cc);
   endfunction

   task automatic release_all();
      for (int i = 0; i < 4; i++) kcol[i] = 4'h0;
   endtask

   task automatic wait_strobe(input int base, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (done_cnt + start_cnt > base) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_busy(input logic lvl, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (kp.busy === lvl) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      logic [3:0] seq [4];
      seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;
      rst = 1'b0;
      release_all();
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (kp.col !== 4'b1110) begin bad++; $display("FAIL reset_col got=%b exp=1110", kp.col); end
      total++; if (kp.data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", kp.data); end
      total++; if (kp.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", kp.done); end
      total++; if (kp.start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", kp.start); end
      total++; if (kp.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", kp.busy); end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (kp.col !== 4'b1110) begin bad++; $display("FAIL dwell_hold got=%b exp=1110", kp.col); end
      @(posedge clk); #1;
      total++; if (kp.col !== seq[0]) begin bad++; $display("FAIL col_step0 got=%b exp=%b", kp.col, seq[0]); end
      for (int i = 1; i < 4; i++) begin
         repeat (4) @(posedge clk);
         #1;
         total++;
         if (kp.col !== seq[i]) begin bad++; $display("FAIL col_step%0d got=%b exp=%b", i, kp.col, seq[i]); end
      end
   endtask

   task automatic test_single_press();
      bit ok;
      int d0;
      d0 = done_cnt;
      kcol[1] = 4'b0010;
      wait_strobe(done_cnt + start_cnt, 100, ok);
      total++; if (!ok) begin bad++; $display("FAIL key5_timeout got=no strobe exp=done"); end
      total++; if (kp.data !== 8'h35) begin bad++; $display("FAIL key5_data got=%h exp=35", kp.data); end
      total++;
      if (last_done_cyc - busy_rise_cyc !== LAT - 1) begin
         bad++; $display("FAIL key5_latency got=%0d exp=%0d", last_done_cyc - busy_rise_cyc + 1, LAT);
      end
      repeat (40) @(negedge clk);
      total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL key5_hold_once got=%0d exp=%0d", done_cnt - d0, 1); end
      release_all();
      wait_busy(1'b0, 100, ok);
      total++; if (!ok) begin bad++; $display("FAIL key5_release_timeout got=busy exp=idle"); end
      total++; if (kp.data !== 8'h35) begin bad++; $display("FAIL key5_data_held got=%h exp=35", kp.data); end
   endtask

   task automatic test_glitch();
      bit ok;
      int d0;
      d0 = done_cnt + start_cnt;
      kcol[2] = 4'b0001;
      wait_busy(1'b1, 100, ok);
      total++; if (!ok) begin bad++; $display("FAIL glitch_detect got=idle exp=busy"); end
      release_all();
      wait_busy(1'b0, 20, ok);
      total++; if (!ok) begin bad++; $display("FAIL glitch_busy_clear got=busy exp=idle"); end
      total++; if (kp.col !== 4'b0111) begin bad++; $display("FAIL glitch_next_col got=%b exp=0111", kp.col); end
      repeat (10) @(negedge clk);
      total++; if (done_cnt + start_cnt !== d0) begin bad++; $display("FAIL glitch_no_strobe got=%0d exp=0", done_cnt + start_cnt - d0); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int d0, t1;
      d0 = done_cnt;
      kcol[3] = 4'b1000;
      wait_strobe(done_cnt + start_cnt, 100, ok);
      total++; if (!ok) begin bad++; $display("FAIL d1_timeout got=no strobe exp=done"); end
      t1 = last_done_cyc;
      repeat (200) @(negedge clk);
      release_all();
      wait_busy(1'b0, 100, ok);
      total++; if (!ok) begin bad++; $display("FAIL d1_release_timeout got=busy exp=idle"); end
      kcol[3] = 4'b1000;
      wait_strobe(done_cnt + start_cnt, 100, ok);
      total++; if (!ok) begin bad++; $display("FAIL d2_timeout got=no strobe exp=done"); end
      total++; if (done_cnt !== d0 + 2) begin bad++; $display("FAIL d_count got=%0d exp=2", done_cnt - d0); end
      total++; if (kp.data !== 8'h44) begin bad++; $display("FAIL d_data got=%h exp=44", kp.data); end
      total++;
      if (last_done_cyc - t1 < DB * SD + 1) begin
         bad++; $display("FAIL d_gap got=%0d exp>=%0d", last_done_cyc - t1, DB * SD + 1);
      end
      release_all();
      wait_busy(1'b0, 100, ok);
   endtask

   task automatic test_priority_star();
      bit ok;
      int ds, ss;
      kcol[2] = 4'b0101;
      wait_strobe(done_cnt + start_cnt, 100, ok);
      total++; if (!ok) begin bad++; $display("FAIL prio_timeout got=no strobe exp=done"); end
      total++; if (kp.data !== 8'h33) begin bad++; $display("FAIL prio_data got=%h exp=33", kp.data); end
      release_all();
      wait_busy(1'b0, 100, ok);
      ds = done_cnt; ss = start_cnt;
      kcol[0] = 4'b1000;
      wait_strobe(done_cnt + start_cnt, 100, ok);
      total++; if (!ok) begin bad++; $display("FAIL star_timeout got=no strobe exp=strobe"); end
      total++; if (kp.data !== 8'h2A) begin bad++; $display("FAIL star_data got=%h exp=2a", kp.data); end
`ifdef KP_STAR_START_EN
      total++;
      if (start_cnt !== ss + 1 || done_cnt !== ds) begin
         bad++; $display("FAIL star_kind got start=%0d done=%0d exp start=1 done=0", start_cnt - ss, done_cnt - ds);
      end
`else
      total++;
      if (start_cnt !== ss || done_cnt !== ds + 1) begin
         bad++; $display("FAIL star_kind got start=%0d done=%0d exp start=0 done=1", start_cnt - ss, done_cnt - ds);
      end
`endif
      release_all();
      wait_busy(1'b0, 100, ok);
   endtask

   task automatic test_reset_mid();
      bit ok;
      int d0;
      d0 = done_cnt + start_cnt;
      kcol[0] = 4'b0100;
      wait_busy(1'b1, 100, ok);
      total++; if (!ok) begin bad++; $display("FAIL k7_detect got=idle exp=busy"); end
      rst = 1'b0;
      #1;
      total++;
      if (kp.col !== 4'b1110 || kp.data !== 8'h00 || kp.busy !== 1'b0 || kp.done !== 1'b0 || kp.start !== 1'b0) begin
         bad++; $display("FAIL midreset_outputs got col=%b data=%h busy=%b done=%b start=%b exp 1110/00/0/0/0",
                         kp.col, kp.data, kp.busy, kp.done, kp.start);
      end
      repeat (3) @(negedge clk);
      total++; if (done_cnt + start_cnt !== d0) begin bad++; $display("FAIL midreset_no_strobe got=%0d exp=0", done_cnt + start_cnt - d0); end
      rst = 1'b1;
      wait_strobe(d0, 100, ok);
      total++; if (!ok) begin bad++; $display("FAIL k7_timeout got=no strobe exp=done"); end
      total++; if (kp.data !== 8'h37) begin bad++; $display("FAIL k7_data got=%h exp=37", kp.data); end
      total++; if (done_cnt + start_cnt !== d0 + 1) begin bad++; $display("FAIL k7_count got=%0d exp=1", done_cnt + start_cnt - d0); end
      release_all();
      wait_busy(1'b0, 100, ok);
   endtask

   task automatic test_random();
      bit ok;
      int rr, cc, er, ds, ss;
      logic [3:0] mask;
      logic [7:0] exp;
      bit is_start;
      for (int it = 0; it < 16; it++) begin
         cc   = $urandom_range(0, 3);
         rr   = $urandom_range(0, 3);
         mask = 4'b0001 << rr;
         if (rr < 3 && $urandom_range(0, 1) == 1) mask = mask | (4'b0001 << $urandom_range(rr + 1, 3));
         er = 3;
         for (int b = 3; b >= 0; b--) if (mask[b]) er = b;
         exp = key_code(er, cc);
`ifdef KP_STAR_START_EN
         is_start = (exp == 8'h2A);
`else
         is_start = 1'b0;
`endif
         repeat ($urandom_range(0, 12)) @(negedge clk);
         ds = done_cnt; ss = start_cnt;
         kcol[cc] = mask;
         wait_strobe(ds + ss, 100, ok);
         total++; if (!ok) begin bad++; $display("FAIL rnd%0d_timeout got=no strobe exp=%h", it, exp); end
         total++; if (kp.data !== exp) begin bad++; $display("FAIL rnd%0d_data got=%h exp=%h", it, kp.data, exp); end
         total++;
         if (last_strobe_cyc - busy_rise_cyc !== LAT - 1) begin
            bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", it, last_strobe_cyc - busy_rise_cyc + 1, LAT);
         end
         total++;
         if ((start_cnt - ss) !== (is_start ? 1 : 0) || (done_cnt - ds) !== (is_start ? 0 : 1)) begin
            bad++; $display("FAIL rnd%0d_kind got start=%0d done=%0d exp start=%0d", it, start_cnt - ss, done_cnt - ds, is_start);
         end
         release_all();
         wait_busy(1'b0, 100, ok);
         total++; if (!ok) begin bad++; $display("FAIL rnd%0d_release got=busy exp=idle", it); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      release_all();
      test_reset();
      test_single_press();
      test_glitch();
      test_back_to_back();
      test_priority_star();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
